// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned MASTER_CPU        = 0;
  localparam int unsigned MASTER_DISP       = 1;
  localparam int unsigned DEF_STARVE_LIMIT  = 4;
  localparam int unsigned DW                = 32;
  localparam int unsigned CNT_W             = 8;

  // Saturating increment for the starvation wait counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-ported data memory: CPU has fixed
// priority, the display/DMA engine is force-granted after a bounded wait.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned AW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rd,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rd,
  output logic          m1_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  logic [CNT_W-1:0] wait_cnt;
  logic             starve;
  logic             m0_rd_take;
  logic             m1_rd_take;

  // Grant decision and memory port mux; no access executes while in reset.
  always_comb begin
    starve = (wait_cnt >= CNT_W'(STARVE_LIMIT));
    m1_gnt = 1'b0;
    m0_gnt = 1'b0;
    if (!rst) begin
      m1_gnt = m1_req & (~m0_req | starve);
      m0_gnt = m0_req & ~m1_gnt;
    end
    mem_a  = m1_gnt ? m1_addr : m0_addr;
    mem_wd = m1_gnt ? m1_wd   : m0_wd;
    mem_we = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  end

  assign m0_rd_take = m0_gnt & ~m0_we;
  assign m1_rd_take = m1_gnt & ~m1_we;

  // Starvation counter: counts consecutive refused master 1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (m1_gnt) begin
      wait_cnt <= '0;
    end else if (m1_req) begin
      wait_cnt <= sat_inc(wait_cnt);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Read-return registers: capture combinational dmem data at the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rd     <= '0;
      m0_rvalid <= 1'b0;
      m1_rd     <= '0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= m0_rd_take;
      m1_rvalid <= m1_rd_take;
      if (m0_rd_take) m0_rd <= mem_rd;
      if (m1_rd_take) m1_rd <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small dmem model.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst;
  logic          m0_req, m0_we;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wd;
  logic          m0_gnt;
  logic [31:0]   m0_rd;
  logic          m0_rvalid;
  logic          m1_req, m1_we;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wd;
  logic          m1_gnt;
  logic [31:0]   m1_rd;
  logic          m1_rvalid;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  logic [31:0]   mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.STARVE_LIMIT(4), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wd     (m0_wd),
    .m0_gnt    (m0_gnt),
    .m0_rd     (m0_rd),
    .m0_rvalid (m0_rvalid),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wd     (m1_wd),
    .m1_gnt    (m1_gnt),
    .m1_rd     (m1_rd),
    .m1_rvalid (m1_rvalid),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: combinational read, write at the rising edge.
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp0, exp1, prev0, prev1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_1234;
    mem[8] = 32'hA5A5_0001;

    // 1. Reset with both masters requesting.
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20; m0_wd = 32'h0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h24; m1_wd = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_eq("rst_m0_gnt", 32'(m0_gnt), 32'h0);
      check_eq("rst_m1_gnt", 32'(m1_gnt), 32'h0);
      check_eq("rst_mem_we", 32'(mem_we), 32'h0);
      check_eq("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
      check_eq("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
      check_eq("rst_m0_rd", m0_rd, 32'h0);
    end
    rst = 1'b0;
    #1;
    check_eq("rel_m0_gnt", 32'(m0_gnt), 32'h1);
    check_eq("rel_m1_gnt", 32'(m1_gnt), 32'h0);
    check_eq("rel_mem_a", mem_a, 32'h20);
    check_eq("rel_mem_we", 32'(mem_we), 32'h0);
    cyc();
    m0_req = 1'b0; m1_req = 1'b0;
    check_eq("rel_m0_rvalid", 32'(m0_rvalid), 32'h1);
    check_eq("rel_m0_rd", m0_rd, 32'hA5A5_0001);
    check_eq("rel_m1_rvalid", 32'(m1_rvalid), 32'h0);
    check_eq("rel_nowrite", mem[9], 32'h0);

    // 2. CPU write then read of 0x10.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wd = 32'hDEAD_BEEF;
    #1;
    check_eq("wr_m0_gnt", 32'(m0_gnt), 32'h1);
    check_eq("wr_mem_we", 32'(mem_we), 32'h1);
    check_eq("wr_mem_wd", mem_wd, 32'hDEAD_BEEF);
    cyc();
    check_eq("wr_no_rvalid", 32'(m0_rvalid), 32'h0);
    m0_we = 1'b0;
    #1;
    check_eq("rd_m0_gnt", 32'(m0_gnt), 32'h1);
    check_eq("rd_mem_we", 32'(mem_we), 32'h0);
    cyc();
    m0_req = 1'b0;
    check_eq("rd_m0_rvalid", 32'(m0_rvalid), 32'h1);
    check_eq("rd_m0_rd", m0_rd, 32'hDEAD_BEEF);
    cyc();
    check_eq("rd_pulse_end", 32'(m0_rvalid), 32'h0);
    check_eq("rd_hold", m0_rd, 32'hDEAD_BEEF);

    // 3. Contention: m1 wins on cycles 4, 9, 14.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0;
    prev0 = 1'b0; prev1 = 1'b0;
    for (int c = 0; c < 15; c++) begin
      exp1 = ((c % 5) == 4);
      exp0 = ~exp1;
      #1;
      check_eq($sformatf("cont%0d_m0_gnt", c), 32'(m0_gnt), 32'(exp0));
      check_eq($sformatf("cont%0d_m1_gnt", c), 32'(m1_gnt), 32'(exp1));
      check_eq($sformatf("cont%0d_m0_rv", c), 32'(m0_rvalid), 32'(prev0));
      check_eq($sformatf("cont%0d_m1_rv", c), 32'(m1_rvalid), 32'(prev1));
      prev0 = exp0; prev1 = exp1;
      cyc();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check_eq("cont_end_m1_rv", 32'(m1_rvalid), 32'h1);
    check_eq("cont_end_m1_rd", m1_rd, 32'h0000_1234);
    cyc();

    // 4. Master 1 alone, read of 0x0.
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0;
    #1;
    check_eq("m1a_gnt", 32'(m1_gnt), 32'h1);
    check_eq("m1a_m0_gnt", 32'(m0_gnt), 32'h0);
    check_eq("m1a_mem_a", mem_a, 32'h0);
    cyc();
    m1_req = 1'b0;
    check_eq("m1a_rvalid", 32'(m1_rvalid), 32'h1);
    check_eq("m1a_rd", m1_rd, 32'h0000_1234);
    check_eq("m1a_m0_rvalid", 32'(m0_rvalid), 32'h0);
    check_eq("m1a_m0_rd", m0_rd, 32'hA5A5_0001);
    cyc();

    // 5. Withdrawn request resets the wait: full 4-cycle wait again.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    m1_req = 1'b1; m1_addr = 32'h4;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq($sformatf("wd%0d_m1_gnt", c), 32'(m1_gnt), 32'h0);
      cyc();
    end
    m1_req = 1'b0;
    cyc();
    m1_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq($sformatf("wd_re%0d_m1_gnt", c), 32'(m1_gnt), 32'(c == 4));
      cyc();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    cyc();

    // 6. Reset in the cycle after a granted CPU read; write suppressed.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    #1;
    check_eq("rr_m0_gnt", 32'(m0_gnt), 32'h1);
    cyc();
    rst = 1'b1; m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wd = 32'h1111_1111;
    #1;
    check_eq("rr_pre_rvalid", 32'(m0_rvalid), 32'h1);
    check_eq("rr_m1_gnt", 32'(m1_gnt), 32'h0);
    check_eq("rr_mem_we", 32'(mem_we), 32'h0);
    cyc();
    rst = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    check_eq("rr_m0_rvalid", 32'(m0_rvalid), 32'h0);
    check_eq("rr_m0_rd", m0_rd, 32'h0);
    m0_req = 1'b1;
    #1;
    check_eq("rr_post_gnt", 32'(m0_gnt), 32'h1);
    cyc();
    m0_req = 1'b0;
    check_eq("rr_post_rd", m0_rd, 32'hDEAD_BEEF);
    check_eq("rr_post_rvalid", 32'(m0_rvalid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter that shares the single-ported data memory between the CPU (master 0) and the display/DMA fetch engine (master 1). It muxes address, write-data and write-enable onto the dmem port, issues per-master grants, and returns registered read data with a valid strobe. Priority is fixed to master 0, with a starvation guard that forces a master 1 grant after a bounded wait. It sits between the CPU load/store path, the display fetch logic and dmem.

Parameters:
STARVE_LIMIT, 4, consecutive cycles master 1 may be refused before it is force-granted; legal range 1..255
AW, 32, address width passed through to dmem (byte address; dmem indexes by a[31:2])

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
m0_req  in  1  CPU requests an access this cycle
m0_we  in  1  CPU access is a write
m0_addr  in  AW  CPU byte address
m0_wd  in  32  CPU write data
m0_gnt  out  1  combinational; CPU access executes this cycle
m0_rd  out  32  registered read data for the last granted CPU read
m0_rvalid  out  1  m0_rd valid; one-cycle pulse
m1_req  in  1  display/DMA requests an access
m1_we  in  1  master 1 access is a write
m1_addr  in  AW  master 1 byte address
m1_wd  in  32  master 1 write data
m1_gnt  out  1  combinational; master 1 access executes this cycle
m1_rd  out  32  registered read data for master 1
m1_rvalid  out  1  m1_rd valid; one-cycle pulse
mem_we  out  1  to dmem we
mem_a  out  AW  to dmem a
mem_wd  out  32  to dmem wd
mem_rd  in  32  from dmem rd (combinational read)

Behaviour:
- One clock, clk. Reset is synchronous, active-high on rst.
- State: wait_cnt (8 bit, saturating), m0_rd, m0_rvalid, m1_rd, m1_rvalid.
- Reset: wait_cnt=0, m0_rd=m1_rd=0, m0_rvalid=m1_rvalid=0. While rst=1: m0_gnt=m1_gnt=0 and mem_we=0.
- Grant (combinational, rst=0):
  - starve = (wait_cnt >= STARVE_LIMIT).
  - m1_gnt = m1_req & (!m0_req | starve).
  - m0_gnt = m0_req & !m1_gnt.
  - At most one grant per cycle.
- Port mux:
  - m1_gnt selects the m1_* signals. Otherwise the m0_* signals drive mem_a/mem_wd.
  - mem_we = (m0_gnt & m0_we) | (m1_gnt & m1_we). With no grant, mem_we=0 and mem_a=m0_addr.
- Latency:
  - A write commits at the rising edge ending the grant cycle.
  - A read is sampled from mem_rd at that same edge into mX_rd. mX_rvalid is high for exactly the following cycle.
  - Read-to-data latency is 1 cycle. Back-to-back reads give back-to-back rvalid pulses.
  - Writes never raise rvalid. mX_rd holds its value when rvalid=0.
- Handshake:
  - A requester holds req/we/addr/wd stable until it sees gnt.
  - It may drop req or change the request the cycle after gnt.
  - A req dropped without a gnt is simply withdrawn; there is no queue.
- wait_cnt update, in priority order:
  - rst → 0.
  - m1_gnt → 0.
  - m1_req & !m1_gnt → min(wait_cnt+1, 255).
  - !m1_req → 0.
- Starvation bound: with both masters requesting continuously, the pattern is STARVE_LIMIT m0 grants, then 1 m1 grant, repeating. With STARVE_LIMIT=4, m1 is granted on cycles 4, 9, 14, ...
- Simultaneous write/write to the same address: only the granted master writes. The loser retries later.
- Reset asserted mid-operation: an access in the reset cycle is suppressed (no gnt, no write). rvalid is cleared even if a read was granted the cycle before.

Decomposition:
- Shared package holds MASTER_CPU=0 and MASTER_DISP=1, the default STARVE_LIMIT, and the data word width 32.
- No sub-module is needed. Grant logic, port mux and the two read-return registers fit one module of about 150 lines.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles with both req=1 → gnt=0, mem_we=0, rvalid=0. After release, m0_gnt=1 in the first cycle.
2. CPU write then read: m0 writes 0xDEADBEEF to 0x10, then reads 0x10 → m0_gnt on both cycles. m0_rvalid pulses one cycle after the read with m0_rd=0xDEADBEEF, and no rvalid after the write.
3. Contention, STARVE_LIMIT=4: both req held for 15 cycles → grant sequence m0,m0,m0,m0,m1 repeating. m1_gnt is high on cycles 4, 9, 14; wait_cnt returns to 0 after each.
4. m1 alone: m1 reads 0x0 holding 0x00001234 → m1_gnt is high the same cycle, m1_rvalid next cycle with m1_rd=0x00001234, m0 outputs unchanged.
5. Withdrawn request: m1_req high for 2 refused cycles, then low → wait_cnt returns to 0. On the next contention, m1 waits a full 4 cycles again.
6. Reset mid-read: m0 read granted in cycle N, rst=1 in cycle N+1 → m0_rvalid=0 and m0_rd=0 after the edge. No write occurs during the reset cycle.
